pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/rv6_pkg.sv | 30 +++
 rtl/pc_ras.sv | 63 ++++++
 rtl/pc_gen.sv | 125 ++++++++++++
 tb/tb_pc_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv6_pkg.sv
// Shared definitions for the fetch front end: redirect-source encoding and
// the default reset vector.
package rv6_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_PRT  = 3'd1,
    SRC_JAL  = 3'd2,
    SRC_RET  = 3'd3,
    SRC_JALR = 3'd4,
    SRC_MISS = 3'd5,
    SRC_TRAP = 3'd6
  } redir_src_e;

  localparam logic [63:0] RESET_VEC_DEF = 64'h0000_0000_8000_0000;

  // A call pushes its return address only when it actually steers fetch.
  function automatic logic is_call_src(input redir_src_e src,
                                       input logic jal_link,
                                       input logic jalr_link);
    logic r;
    case (src)
      SRC_JAL:  r = jal_link;
      SRC_JALR: r = jalr_link;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry
// and the count saturates.
module pc_ras #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   cnt
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;   // next free slot; top entry sits just below
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx_s;

  // Pointer and count next state.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      cnt_d = (cnt_q == FULL) ? FULL : cnt_q + CW'(1);
    end else if (pop && (cnt_q != {CW{1'b0}})) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[ptr_q] <= push_data;
    end
  end

  assign top_idx_s = ptr_q - PW'(1);
  assign top       = mem_q[top_idx_s];
  assign cnt       = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirect mux with a return-address stack
// for call/return prediction.
module pc_gen
  import rv6_pkg::*;
#(
  parameter int          XLEN      = 64,
  parameter logic [63:0] RESET_VEC = RESET_VEC_DEF,
  parameter int          OFFS_W    = 13,
  parameter int          RAS_DEPTH = 8,
  parameter int          C_EXT     = 1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       stall,
  input  logic                       trap_taken,
  input  logic [XLEN-1:0]            trap_addr,
  input  logic                       pr_miss,
  input  logic [XLEN-1:0]            br_addr,
  input  logic                       jalr_taken,
  input  logic [XLEN-1:0]            jalr_addr,
  input  logic                       jalr_link,
  input  logic                       ret_pred,
  input  logic                       jal_taken,
  input  logic [XLEN-1:0]            jal_addr,
  input  logic                       jal_link,
  input  logic [XLEN-1:0]            link_addr,
  input  logic                       pr_taken,
  input  logic [OFFS_W-1:0]          pr_offs,
  input  logic                       ins_c,
  output logic [XLEN-1:0]            pc,
  output logic [$clog2(RAS_DEPTH):0] ras_cnt,
  output logic                       ret_hit
);

  localparam int              CW     = $clog2(RAS_DEPTH) + 1;
  localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VEC);

  function automatic logic [XLEN-1:0] even(input logic [XLEN-1:0] a);
    return {a[XLEN-1:1], 1'b0};
  endfunction

  logic [XLEN-1:0] pc_q, pc_d;
  logic            ret_hit_q, ret_hit_d;
  logic [XLEN-1:0] ras_top_s, offs_ext_s, step_s;
  logic [CW-1:0]   ras_cnt_s;
  logic            push_s, pop_s;
  redir_src_e      src_s;

  assign offs_ext_s = {{(XLEN-OFFS_W){pr_offs[OFFS_W-1]}}, pr_offs};
  assign step_s     = ((C_EXT != 0) && ins_c) ? XLEN'(2) : XLEN'(4);

  // Pick the winning redirect source; a return with an empty stack falls through.
  always_comb begin
    src_s = SRC_SEQ;
    if (trap_taken) begin
      src_s = SRC_TRAP;
    end else if (pr_miss) begin
      src_s = SRC_MISS;
    end else if (jalr_taken) begin
      src_s = SRC_JALR;
    end else if (ret_pred && (ras_cnt_s != {CW{1'b0}})) begin
      src_s = SRC_RET;
    end else if (jal_taken) begin
      src_s = SRC_JAL;
    end else if (pr_taken) begin
      src_s = SRC_PRT;
    end else begin
      src_s = SRC_SEQ;
    end
  end

  // Next PC, stack control and return-hit flag.
  always_comb begin
    pc_d      = pc_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ret_hit_d = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else begin
      push_s    = is_call_src(src_s, jal_link, jalr_link);
      pop_s     = (src_s == SRC_RET);
      ret_hit_d = (src_s == SRC_RET);
      case (src_s)
        SRC_TRAP: pc_d = even(trap_addr);
        SRC_MISS: pc_d = even(br_addr);
        SRC_JALR: pc_d = even(jalr_addr);
        SRC_RET:  pc_d = even(ras_top_s);
        SRC_JAL:  pc_d = even(jal_addr);
        SRC_PRT:  pc_d = pc_q + offs_ext_s;
        SRC_SEQ:  pc_d = pc_q + step_s;
        default:  pc_d = pc_q + step_s;
      endcase
    end
  end

  // PC and return-hit registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q      <= RST_PC;
      ret_hit_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ret_hit_q <= ret_hit_d;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .clr       (clr),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (link_addr),
    .top       (ras_top_s),
    .cnt       (ras_cnt_s)
  );

  assign pc      = pc_q;
  assign ras_cnt = ras_cnt_s;
  assign ret_hit = ret_hit_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen; two instances (C_EXT=1 and 0)
// share stimulus and are checked against a queue-based reference model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        clr, stall, trap_taken, pr_miss, jalr_taken, jalr_link;
  logic        ret_pred, jal_taken, jal_link, pr_taken, ins_c;
  logic [63:0] trap_addr, br_addr, jalr_addr, jal_addr, link_addr;
  logic [12:0] pr_offs;
  logic [63:0] pc1, pc0;
  logic [3:0]  cnt1, cnt0;
  logic        rh1, rh0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_pc1, m_pc0, held;
  logic [63:0] m_ras[$];
  logic        m_rh;

  always #5 clk = ~clk;

  pc_gen #(.C_EXT(1)) dut_c1 (
    .clk(clk), .clr(clr), .stall(stall),
    .trap_taken(trap_taken), .trap_addr(trap_addr),
    .pr_miss(pr_miss), .br_addr(br_addr),
    .jalr_taken(jalr_taken), .jalr_addr(jalr_addr), .jalr_link(jalr_link),
    .ret_pred(ret_pred),
    .jal_taken(jal_taken), .jal_addr(jal_addr), .jal_link(jal_link),
    .link_addr(link_addr), .pr_taken(pr_taken), .pr_offs(pr_offs),
    .ins_c(ins_c), .pc(pc1), .ras_cnt(cnt1), .ret_hit(rh1)
  );

  pc_gen #(.C_EXT(0)) dut_c0 (
    .clk(clk), .clr(clr), .stall(stall),
    .trap_taken(trap_taken), .trap_addr(trap_addr),
    .pr_miss(pr_miss), .br_addr(br_addr),
    .jalr_taken(jalr_taken), .jalr_addr(jalr_addr), .jalr_link(jalr_link),
    .ret_pred(ret_pred),
    .jal_taken(jal_taken), .jal_addr(jal_addr), .jal_link(jal_link),
    .link_addr(link_addr), .pr_taken(pr_taken), .pr_offs(pr_offs),
    .ins_c(ins_c), .pc(pc0), .ras_cnt(cnt0), .ret_hit(rh0)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    clr = 1'b0; stall = 1'b0; trap_taken = 1'b0; pr_miss = 1'b0;
    jalr_taken = 1'b0; jalr_link = 1'b0; ret_pred = 1'b0;
    jal_taken = 1'b0; jal_link = 1'b0; pr_taken = 1'b0; ins_c = 1'b0;
    trap_addr = 64'h0; br_addr = 64'h0; jalr_addr = 64'h0; jal_addr = 64'h0;
    link_addr = 64'h0; pr_offs = 13'h0;
  endtask

  function automatic logic [63:0] clr0(input logic [63:0] a);
    return a & ~64'h1;
  endfunction

  task automatic push_ret(input logic [63:0] a);
    m_ras.push_back(a);
    if (m_ras.size() > 8) void'(m_ras.pop_front());
  endtask

  // Reference: apply the priority rules to the abstract state for this cycle's inputs.
  task automatic model_step();
    logic [63:0] sext;
    logic [63:0] tgt;
    sext = {{51{pr_offs[12]}}, pr_offs};
    m_rh = 1'b0;
    if (clr) begin
      m_pc1 = 64'h8000_0000; m_pc0 = 64'h8000_0000; m_ras.delete();
    end else if (stall) begin
      m_rh = 1'b0;
    end else if (trap_taken) begin
      m_pc1 = clr0(trap_addr); m_pc0 = m_pc1;
    end else if (pr_miss) begin
      m_pc1 = clr0(br_addr); m_pc0 = m_pc1;
    end else if (jalr_taken) begin
      m_pc1 = clr0(jalr_addr); m_pc0 = m_pc1;
      if (jalr_link) push_ret(link_addr);
    end else if (ret_pred && m_ras.size() > 0) begin
      tgt = m_ras.pop_back();
      m_pc1 = clr0(tgt); m_pc0 = m_pc1; m_rh = 1'b1;
    end else if (jal_taken) begin
      m_pc1 = clr0(jal_addr); m_pc0 = m_pc1;
      if (jal_link) push_ret(link_addr);
    end else if (pr_taken) begin
      m_pc1 = m_pc1 + sext; m_pc0 = m_pc0 + sext;
    end else begin
      m_pc1 = m_pc1 + (ins_c ? 64'd2 : 64'd4);
      m_pc0 = m_pc0 + 64'd4;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_val("pc_c1", pc1, m_pc1);
    check_val("pc_c0", pc0, m_pc0);
    check_val("ras_cnt_c1", 64'(cnt1), 64'(m_ras.size()));
    check_val("ras_cnt_c0", 64'(cnt0), 64'(m_ras.size()));
    check_val("ret_hit_c1", 64'(rh1), 64'(m_rh));
    check_val("ret_hit_c0", 64'(rh0), 64'(m_rh));
  endtask

  initial begin
    set_idle();
    m_pc1 = 64'h0; m_pc0 = 64'h0; m_rh = 1'b0;
    clr = 1'b1;
    step();
    step();
    check_val("reset_pc", pc1, 64'h8000_0000);
    check_val("reset_cnt", 64'(cnt1), 64'd0);

    // Sequential fetch after reset.
    set_idle();
    step(); check_val("seq1", pc1, 64'h8000_0004);
    step(); check_val("seq2", pc1, 64'h8000_0008);
    step(); check_val("seq3", pc1, 64'h8000_000C);
    ins_c = 1'b1;
    step();
    check_val("cstep_c1", pc1, 64'h8000_000E);
    check_val("cstep_c0", pc0, 64'h8000_0010);

    // Call then return.
    set_idle();
    jal_taken = 1'b1; jal_link = 1'b1;
    jal_addr = 64'h8000_1000; link_addr = 64'h8000_0014;
    step();
    check_val("call_pc", pc1, 64'h8000_1000);
    check_val("call_cnt", 64'(cnt1), 64'd1);
    set_idle(); ret_pred = 1'b1;
    step();
    check_val("ret_pc", pc1, 64'h8000_0014);
    check_val("ret_hit", 64'(rh1), 64'd1);
    check_val("ret_cnt", 64'(cnt1), 64'd0);
    set_idle();
    step();
    check_val("ret_hit_drop", 64'(rh1), 64'd0);

    // Overflow: nine calls into an eight-deep stack, then nine returns.
    for (int k = 1; k <= 9; k++) begin
      set_idle();
      jal_taken = 1'b1; jal_link = 1'b1;
      jal_addr = 64'h8000_4000; link_addr = 64'(k) * 64'h100;
      step();
    end
    check_val("ovf_cnt", 64'(cnt1), 64'd8);
    for (int j = 1; j <= 9; j++) begin
      set_idle(); ret_pred = 1'b1;
      step();
      if (j <= 8) check_val("ovf_pop", pc1, 64'(10 - j) * 64'h100);
    end
    check_val("ovf_fall", pc0, 64'h204);
    check_val("ovf_cnt0", 64'(cnt1), 64'd0);

    // Everything at once: trap wins, stack untouched.
    set_idle();
    jal_taken = 1'b1; jal_link = 1'b1; jal_addr = 64'h8000_3000; link_addr = 64'h8000_0AB0;
    step();
    trap_taken = 1'b1; trap_addr = 64'h8000_2001;
    pr_miss = 1'b1; br_addr = 64'h8000_5000;
    jalr_taken = 1'b1; jalr_link = 1'b1; jalr_addr = 64'h8000_6000;
    ret_pred = 1'b1; jal_addr = 64'h8000_7000; link_addr = 64'h1234;
    pr_taken = 1'b1; pr_offs = 13'h010;
    step();
    check_val("all_pc", pc1, 64'h8000_2000);
    check_val("all_cnt", 64'(cnt1), 64'd1);
    set_idle(); ret_pred = 1'b1;
    step();
    check_val("all_ras_kept", pc1, 64'h8000_0AB0);

    // Stall holds against a mispredict; reset overrides stall.
    set_idle();
    jal_taken = 1'b1; jal_link = 1'b1; jal_addr = 64'h8000_8000; link_addr = 64'h8000_0100;
    step();
    held = pc1;
    set_idle(); stall = 1'b1; pr_miss = 1'b1; br_addr = 64'h8000_9000;
    step(); step();
    check_val("stall_pc", pc1, held);
    check_val("stall_cnt", 64'(cnt1), 64'd1);
    clr = 1'b1;
    step();
    check_val("clr_pc", pc1, 64'h8000_0000);
    check_val("clr_cnt", 64'(cnt1), 64'd0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      set_idle();
      clr        = ($urandom_range(199) == 0);
      stall      = ($urandom_range(9) == 0);
      trap_taken = ($urandom_range(29) == 0);
      pr_miss    = ($urandom_range(19) == 0);
      jalr_taken = ($urandom_range(9) == 0);
      jalr_link  = 1'($urandom);
      ret_pred   = ($urandom_range(3) == 0);
      jal_taken  = ($urandom_range(4) == 0);
      jal_link   = 1'($urandom);
      pr_taken   = ($urandom_range(5) == 0);
      ins_c      = 1'($urandom);
      trap_addr  = {$urandom, $urandom};
      br_addr    = {$urandom, $urandom};
      jalr_addr  = {$urandom, $urandom};
      jal_addr   = {$urandom, $urandom};
      link_addr  = {$urandom, $urandom} & ~64'h1;
      pr_offs    = 13'($urandom) & ~13'h1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
